// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared constants, lamp codes and digit-slot enum for the traffic display
package traffic_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [6:0] SEG_DASH   = 7'h40;

  localparam logic [1:0] LAMP_GREEN    = 2'b01;
  localparam logic [1:0] LAMP_RED      = 2'b10;
  localparam logic [1:0] LAMP_CONFLICT = 2'b11;

  typedef enum logic [1:0] {
    A_L = 2'd0,
    A_H = 2'd1,
    B_L = 2'd2,
    B_H = 2'd3
  } slot_e;

  // Returns {lamp_a, lamp_b}; two greens are never produced.
  function automatic logic [3:0] lamp_codes(input logic a_green, input logic b_green);
    logic [3:0] codes;
    case ({a_green, b_green})
      2'b10:   codes = {LAMP_GREEN, LAMP_RED};
      2'b01:   codes = {LAMP_RED, LAMP_GREEN};
      2'b00:   codes = {LAMP_RED, LAMP_RED};
      default: codes = {LAMP_CONFLICT, LAMP_CONFLICT};
    endcase
    return codes;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD to seven-segment decoder, active-high {g,f,e,d,c,b,a}
module bcd_to_seg
  import traffic_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_lz_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (digit_i == BLANK_CODE || (blank_lz_i && digit_i == 4'd0)) begin
      seg_o = 7'h00;
    end else begin
      case (digit_i)
        4'd0:    seg_o = 7'h3F;
        4'd1:    seg_o = 7'h06;
        4'd2:    seg_o = 7'h5B;
        4'd3:    seg_o = 7'h4F;
        4'd4:    seg_o = 7'h66;
        4'd5:    seg_o = 7'h6D;
        4'd6:    seg_o = 7'h7D;
        4'd7:    seg_o = 7'h07;
        4'd8:    seg_o = 7'h7F;
        4'd9:    seg_o = 7'h6F;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/traffic_display_scan.sv
// rtl/traffic_display_scan.sv - frame-shadowed 4-digit seven-segment scan with lamp-code outputs
module traffic_display_scan
  import traffic_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 4,
  parameter bit          ACTIVE_LOW_SEG = 1'b1,
  parameter bit          LZ_BLANK       = 1'b1
) (
  input  logic       CLK,
  input  logic       R,
  input  logic [3:0] A_Time_L,
  input  logic [3:0] A_Time_H,
  input  logic [3:0] B_Time_L,
  input  logic [3:0] B_Time_H,
  input  logic       A_Light,
  input  logic       B_Light,
  output logic [6:0] SEG,
  output logic [3:0] DIG_EN,
  output logic [1:0] LAMP_A,
  output logic [1:0] LAMP_B,
  output logic       FRAME_DONE
);

  localparam logic [7:0] PRESC_LAST = 8'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_OFF    = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;

  logic [7:0]      presc_q, presc_d;
  slot_e           idx_q, idx_d;
  logic [3:0][3:0] shadow_q, shadow_d;
  logic            primed_q, primed_d;
  logic [6:0]      seg_q, seg_d, seg_raw;
  logic [3:0]      dig_en_q, dig_en_d;
  logic [1:0]      lamp_a_q, lamp_a_d, lamp_b_q, lamp_b_d;
  logic            frame_done_q, frame_done_d;
  logic            blank_lz;

  always_comb begin
    presc_d  = presc_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    primed_d = 1'b1;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = slot_e'(idx_q + 2'd1);
    end else begin
      presc_d = presc_q + 8'd1;
    end
    if (!primed_q || (idx_q == B_H && presc_q == PRESC_LAST)) begin
      shadow_d = {B_Time_H, B_Time_L, A_Time_H, A_Time_L};
    end
  end

  // Outputs are computed from the next state so the registered pins line up with the counters.
  assign blank_lz = LZ_BLANK && (idx_d == A_H || idx_d == B_H);

  bcd_to_seg u_dec (
    .digit_i    (shadow_d[idx_d]),
    .blank_lz_i (blank_lz),
    .seg_o      (seg_raw)
  );

  always_comb begin
    dig_en_d     = 4'b0000;
    seg_d        = SEG_OFF;
    frame_done_d = (idx_d == B_H) && (presc_d == PRESC_LAST);
    if (presc_d != 8'd0) begin
      dig_en_d = 4'b0001 << idx_d;
      seg_d    = ACTIVE_LOW_SEG ? ~seg_raw : seg_raw;
    end
    {lamp_a_d, lamp_b_d} = lamp_codes(A_Light, B_Light);
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      presc_q      <= '0;
      idx_q        <= A_L;
      shadow_q     <= {4{BLANK_CODE}};
      primed_q     <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_en_q     <= 4'b0000;
      lamp_a_q     <= 2'b00;
      lamp_b_q     <= 2'b00;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      primed_q     <= primed_d;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
      lamp_a_q     <= lamp_a_d;
      lamp_b_q     <= lamp_b_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign SEG        = seg_q;
  assign DIG_EN     = dig_en_q;
  assign LAMP_A     = lamp_a_q;
  assign LAMP_B     = lamp_b_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_traffic_display_scan.sv
// tb/tb_traffic_display_scan.sv - self-checking bench for traffic_display_scan with two parameter sets
module tb_traffic_display_scan;

  logic       CLK;
  logic       R;
  logic [3:0] a_l, a_h, b_l, b_h;
  logic       a_lt, b_lt;

  logic [6:0] seg0, seg1;
  logic [3:0] den0, den1;
  logic [1:0] la0, lb0, la1, lb1;
  logic       fd0, fd1;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;
  bit rst_state = 1'b1;

  logic [3:0] h_dig [0:2047][0:3];
  logic       h_a   [0:2047];
  logic       h_b   [0:2047];

  localparam logic [6:0] SEGTAB [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  traffic_display_scan dut0 (
    .CLK(CLK), .R(R),
    .A_Time_L(a_l), .A_Time_H(a_h), .B_Time_L(b_l), .B_Time_H(b_h),
    .A_Light(a_lt), .B_Light(b_lt),
    .SEG(seg0), .DIG_EN(den0), .LAMP_A(la0), .LAMP_B(lb0), .FRAME_DONE(fd0)
  );

  traffic_display_scan #(.SCAN_DIV(3), .ACTIVE_LOW_SEG(1'b0), .LZ_BLANK(1'b0)) dut1 (
    .CLK(CLK), .R(R),
    .A_Time_L(a_l), .A_Time_H(a_h), .B_Time_L(b_l), .B_Time_H(b_h),
    .A_Light(a_lt), .B_Light(b_lt),
    .SEG(seg1), .DIG_EN(den1), .LAMP_A(la1), .LAMP_B(lb1), .FRAME_DONE(fd1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [3:0] dg, input bit lz_hi, input bit act_low);
    logic [6:0] s;
    if (dg == 4'hF || (lz_hi && dg == 4'd0)) s = 7'h00;
    else if (dg <= 4'd9) s = SEGTAB[int'(dg)];
    else s = 7'h40;
    return act_low ? ~s : s;
  endfunction

  task automatic check_dut(input string nm, input int d, input bit act_low, input bit lz,
                           input logic [6:0] seg, input logic [3:0] den,
                           input logic [1:0] la, input logic [1:0] lb, input logic fd);
    int p, idx, pr, fs, sc;
    logic [1:0] ea, eb;
    p   = t % (4 * d);
    idx = p / d;
    pr  = p % d;
    fs  = t - p;
    sc  = (fs == 0) ? 0 : fs - 1;
    chk({nm, ".dig_en"}, 32'(den), (pr == 0) ? 32'd0 : (32'd1 << idx));
    if (pr != 0) chk({nm, ".seg"}, 32'(seg), 32'(exp_seg(h_dig[sc][idx], lz && (idx % 2 == 1), act_low)));
    chk({nm, ".frame_done"}, 32'(fd), 32'((idx == 3 && pr == d - 1) ? 1 : 0));
    if (t == 0) begin
      ea = 2'b00;
      eb = 2'b00;
    end else begin
      ea = (h_a[t-1] && h_b[t-1]) ? 2'b11 : (h_a[t-1] ? 2'b01 : 2'b10);
      eb = (h_a[t-1] && h_b[t-1]) ? 2'b11 : (h_b[t-1] ? 2'b01 : 2'b10);
    end
    chk({nm, ".lamp_a"}, 32'(la), 32'(ea));
    chk({nm, ".lamp_b"}, 32'(lb), 32'(eb));
  endtask

  task automatic check_reset();
    chk("rst.dig_en0", 32'(den0), 32'd0);
    chk("rst.seg0", 32'(seg0), 32'h7F);
    chk("rst.lamps0", 32'({la0, lb0}), 32'd0);
    chk("rst.fd0", 32'(fd0), 32'd0);
    chk("rst.dig_en1", 32'(den1), 32'd0);
    chk("rst.seg1", 32'(seg1), 32'h00);
    chk("rst.lamps1", 32'({la1, lb1}), 32'd0);
    chk("rst.fd1", 32'(fd1), 32'd0);
  endtask

  task automatic cycle();
    @(negedge CLK);
    if (rst_state) check_reset();
    else begin
      check_dut("d0", 4, 1'b1, 1'b1, seg0, den0, la0, lb0, fd0);
      check_dut("d1", 3, 1'b0, 1'b0, seg1, den1, la1, lb1, fd1);
    end
    if (!R && t < 2048) begin
      h_dig[t][0] = a_l;
      h_dig[t][1] = a_h;
      h_dig[t][2] = b_l;
      h_dig[t][3] = b_h;
      h_a[t] = a_lt;
      h_b[t] = b_lt;
    end
    @(posedge CLK);
    #1;
    if (R) begin
      t = 0;
      rst_state = 1'b1;
    end else begin
      t++;
      rst_state = 1'b0;
    end
  endtask

  task automatic set_digits(input logic [3:0] al, input logic [3:0] ah,
                            input logic [3:0] bl, input logic [3:0] bh);
    a_l = al; a_h = ah; b_l = bl; b_h = bh;
  endtask

  initial begin
    R = 1'b1;
    set_digits(4'd9, 4'd8, 4'd9, 4'd8);
    a_lt = 1'b1; b_lt = 1'b0;
    repeat (3) cycle();

    R = 1'b0;
    repeat (6) cycle();
    a_l = 4'd7;
    repeat (40) cycle();

    a_lt = 1'b1; b_lt = 1'b0; cycle();
    a_lt = 1'b0; b_lt = 1'b1; cycle();
    a_lt = 1'b0; b_lt = 1'b0; cycle();
    a_lt = 1'b1; b_lt = 1'b1; cycle();
    cycle();

    set_digits(4'd5, 4'd0, 4'd3, 4'd0);
    repeat (24) cycle();
    set_digits(4'hF, 4'hF, 4'hF, 4'hF);
    repeat (24) cycle();
    set_digits(4'hC, 4'd1, 4'hA, 4'hE);
    repeat (24) cycle();

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: a_l = 4'($urandom_range(0, 15));
          1: a_h = 4'($urandom_range(0, 15));
          2: b_l = 4'($urandom_range(0, 15));
          default: b_h = 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 3) == 0) begin
        a_lt = 1'($urandom_range(0, 1));
        b_lt = 1'($urandom_range(0, 1));
      end
      cycle();
    end

    set_digits(4'd9, 4'd8, 4'd9, 4'd8);
    for (int k = 0; k < 16 && (t % 16) != 10; k++) cycle();
    R = 1'b1;
    cycle();
    R = 1'b0;
    set_digits(4'd2, 4'd1, 4'd6, 4'd4);
    repeat (60) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
